// File: rtl/pci_init32.sv
// rtl/pci_init32.sv - single-data-phase 32-bit PCI bus initiator
module pci_init32 #(
  parameter logic [3:0] CMD_RD     = 4'b0110,
  parameter logic [3:0] CMD_WR     = 4'b0111,
  parameter int         DEVSEL_TMO = 5,
  parameter int         TRDY_TMO   = 16
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        start,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be_,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] rdata,
  output logic        req_,
  input  logic        gnt_,
  input  logic [31:0] ad_i,
  output logic [31:0] ad_o,
  output logic        ad_oe,
  output logic [3:0]  cbe_o_,
  input  logic        frame_i_,
  input  logic        irdy_i_,
  output logic        frame_o_,
  output logic        irdy_o_,
  output logic        ctl_oe,
  input  logic        trdy_,
  input  logic        devsel_,
  input  logic        stop_
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_DATA,
    S_TURN
  } state_t;

  // cnt is 0 in the address clock and equals the data-clock number during DATA;
  // master abort is taken on the last data clock so done lands DEVSEL_TMO clocks after ADDR.
  localparam logic [4:0] DEVSEL_LAST = 5'(DEVSEL_TMO - 1);
  localparam logic [4:0] TRDY_LAST   = 5'(TRDY_TMO);

  state_t      state, state_n;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  cnt;
  logic        devsel_seen;
  logic        fin;
  logic        xfer;
  logic [1:0]  fin_status;

  always_comb begin
    state_n    = state;
    req_       = 1'b1;
    frame_o_   = 1'b1;
    irdy_o_    = 1'b1;
    cbe_o_     = 4'hF;
    ad_o       = '0;
    ad_oe      = 1'b0;
    ctl_oe     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fin        = 1'b0;
    xfer       = 1'b0;
    fin_status = 2'b00;

    case (state)
      S_IDLE: begin
        if (start) state_n = S_ARB;
      end

      S_ARB: begin
        busy = 1'b1;
        req_ = 1'b0;
        if (!gnt_ && frame_i_ && irdy_i_) state_n = S_ADDR;
      end

      S_ADDR: begin
        busy     = 1'b1;
        frame_o_ = 1'b0;
        ctl_oe   = 1'b1;
        ad_oe    = 1'b1;
        ad_o     = addr_q;
        cbe_o_   = wr_q ? CMD_WR : CMD_RD;
        state_n  = S_DATA;
      end

      S_DATA: begin
        busy    = 1'b1;
        irdy_o_ = 1'b0;
        ctl_oe  = 1'b1;
        cbe_o_  = be_q;
        ad_oe   = wr_q;
        ad_o    = wr_q ? wdata_q : '0;
        // Exit conditions in priority order; only one data phase is ever attempted.
        if (!trdy_ && !devsel_) begin
          fin        = 1'b1;
          xfer       = 1'b1;
          fin_status = 2'b00;
        end else if (!stop_ && !devsel_) begin
          fin        = 1'b1;
          fin_status = 2'b10;
        end else if (!stop_ && devsel_ && devsel_seen) begin
          fin        = 1'b1;
          fin_status = 2'b11;
        end else if (!devsel_seen && devsel_ && cnt >= DEVSEL_LAST) begin
          fin        = 1'b1;
          fin_status = 2'b01;
        end else if (cnt >= TRDY_LAST) begin
          fin        = 1'b1;
          fin_status = 2'b11;
        end
        if (fin) state_n = S_TURN;
      end

      S_TURN: begin
        ctl_oe  = 1'b1;
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state       <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= 4'hF;
      cnt         <= '0;
      devsel_seen <= 1'b0;
      status      <= 2'b00;
      rdata       <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be_;
      end
      if (state_n == S_ADDR) begin
        cnt         <= '0;
        devsel_seen <= 1'b0;
      end else if (cnt != 5'h1F) begin
        cnt <= cnt + 5'd1;
      end
      if (state == S_DATA && !devsel_) devsel_seen <= 1'b1;
      if (fin) status <= fin_status;
      if (xfer && !wr_q) rdata <= ad_i;
    end
  end

endmodule
